// File: rtl/int_timer_pkg.sv
// Shared constants for the interrupt timer: register offsets, CTRL/STATUS bit
// positions and the default bus address of the register window.
package int_timer_pkg;

    localparam logic [31:0] DEFAULT_ADDR_BASE = 32'hF000_0000;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_LOAD   = 2'd1,
        REG_COUNT  = 2'd2,
        REG_STATUS = 2'd3
    } reg_off_e;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_TIE         = 2;
    localparam int CTRL_EIE         = 3;
    localparam int CTRL_WIDTH       = 4;

    localparam int STAT_TPEND = 0;
    localparam int STAT_EPEND = 1;

endpackage

// File: rtl/int_timer_if.sv
// Single-cycle core data-bus slice seen by the timer: address, write data and
// strobe in; combinational read data and window select out.
interface int_timer_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        sel;

    modport master (output addr, wdata, we, input rdata, sel);
    modport slave  (input addr, wdata, we, output rdata, sel);
endinterface

// File: rtl/int_timer_sync_edge.sv
// Multi-flop synchronizer followed by a rising-edge detector; emits a one-cycle
// pulse per clean 0->1 transition of an asynchronous input.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_pulse
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic [STAGES:0]   armed_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= '0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], async_in};
            prev_q  <= sync_q[STAGES-1];
            armed_q <= {armed_q[STAGES-1:0], 1'b1};
        end
    end

    // Detection stays off until prev_q holds a real sample, so a level already
    // high at reset release is not mistaken for an edge.
    assign rise_pulse = armed_q[STAGES] & sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/int_timer.sv
// Memory-mapped down-counting timer with one-shot/auto-reload modes and a
// synchronized external interrupt input, merged onto a single level request.
module int_timer
    import int_timer_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = DEFAULT_ADDR_BASE,
    parameter int          SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    int_timer_if.slave   bus,
    input  logic         ext_irq,
    output logic         INT0
);

    logic [CTRL_WIDTH-1:0] ctrl_q;
    logic [31:0]           load_q;
    logic [31:0]           count_q;
    logic                  tpend_q;
    logic                  epend_q;

    reg_off_e    off;
    logic        wr;
    logic        expire;
    logic        ext_rise;
    logic [31:0] rd_mux;
    logic        unused_addr_bits;

    assign bus.sel          = (bus.addr[31:4] == ADDR_BASE[31:4]);
    assign off              = reg_off_e'(bus.addr[3:2]);
    assign wr               = bus.sel && bus.we;
    assign expire           = ctrl_q[CTRL_EN] && (count_q == 32'd0);
    assign unused_addr_bits = &{1'b0, bus.addr[1:0]};

    sync_edge #(.STAGES(SYNC_STAGES)) u_ext_sync (
        .clk        (clk),
        .rst        (rst),
        .async_in   (ext_irq),
        .rise_pulse (ext_rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= '0;
            load_q  <= '0;
            count_q <= '0;
            tpend_q <= 1'b0;
            epend_q <= 1'b0;
        end else begin
            // A CTRL write overrides the one-shot self-disable in the same cycle.
            if (wr && off == REG_CTRL)
                ctrl_q <= bus.wdata[CTRL_WIDTH-1:0];
            else if (expire && !ctrl_q[CTRL_AUTO_RELOAD])
                ctrl_q[CTRL_EN] <= 1'b0;

            if (wr && off == REG_LOAD)
                load_q <= bus.wdata;

            if (wr && off == REG_LOAD)
                count_q <= bus.wdata;
            else if (expire)
                count_q <= ctrl_q[CTRL_AUTO_RELOAD] ? load_q : 32'd0;
            else if (ctrl_q[CTRL_EN])
                count_q <= count_q - 32'd1;

            // Setting a pending bit takes priority over a same-cycle W1C.
            if (expire)
                tpend_q <= 1'b1;
            else if (wr && off == REG_STATUS && bus.wdata[STAT_TPEND])
                tpend_q <= 1'b0;

            if (ext_rise)
                epend_q <= 1'b1;
            else if (wr && off == REG_STATUS && bus.wdata[STAT_EPEND])
                epend_q <= 1'b0;
        end
    end

    // NOTE: assign a default first in always_comb so no path can infer a latch.
    always_comb begin
        rd_mux = '0;
        unique case (off)
            REG_CTRL:   rd_mux = {{(32-CTRL_WIDTH){1'b0}}, ctrl_q};
            REG_LOAD:   rd_mux = load_q;
            REG_COUNT:  rd_mux = count_q;
            REG_STATUS: rd_mux = {30'd0, epend_q, tpend_q};
        endcase
    end

    assign bus.rdata = bus.sel ? rd_mux : 32'd0;
    assign INT0      = (tpend_q & ctrl_q[CTRL_TIE]) | (epend_q & ctrl_q[CTRL_EIE]);

endmodule

// File: tb/tb_int_timer.sv
// Directed self-checking bench for int_timer: countdown, one-shot, clear race,
// external edge, address decode and asynchronous reset.
`timescale 1ns/100ps
module tb_int_timer;
    import int_timer_pkg::*;

    localparam logic [31:0] BASE = 32'hF000_0000;

    logic clk;
    logic rst;
    logic ext_irq;
    logic INT0;
    int   checks;
    int   failures;

    int_timer_if bus ();

    int_timer #(.ADDR_BASE(BASE), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .ext_irq (ext_irq),
        .INT0    (INT0)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] off, input logic [31:0] data);
        bus.addr  = BASE + {28'd0, off, 2'b00};
        bus.wdata = data;
        bus.we    = 1'b1;
        tick();
        bus.we    = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] off, input logic [31:0] exp);
        bus.addr = BASE + {28'd0, off, 2'b00};
        bus.we   = 1'b0;
        #1;
        check(tag, bus.rdata, exp);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        ext_irq   = 1'b0;
        bus.addr  = BASE;
        bus.wdata = 32'd0;
        bus.we    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check_reg("rst_ctrl",   2'd0, 32'd0);
        check_reg("rst_load",   2'd1, 32'd0);
        check_reg("rst_count",  2'd2, 32'd0);
        check_reg("rst_status", 2'd3, 32'd0);
        check("rst_int0", {31'd0, INT0}, 32'd0);
        check("sel_in_window", {31'd0, bus.sel}, 32'd1);

        // Countdown with auto-reload: 3,2,1,0,3
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'h7);
        check_reg("cd_count3", 2'd2, 32'd3);
        tick(); check_reg("cd_count2", 2'd2, 32'd2);
        tick(); check_reg("cd_count1", 2'd2, 32'd1);
        tick(); check_reg("cd_count0", 2'd2, 32'd0);
        check_reg("cd_status_pre", 2'd3, 32'd0);
        check("cd_int0_pre", {31'd0, INT0}, 32'd0);
        tick(); check_reg("cd_reload", 2'd2, 32'd3);
        check_reg("cd_tpend", 2'd3, 32'd1);
        check("cd_int0", {31'd0, INT0}, 32'd1);
        bus_write(2'd0, 32'h0);
        bus_write(2'd3, 32'h1);
        check_reg("cd_clr_status", 2'd3, 32'd0);
        check_reg("cd_hold_count", 2'd2, 32'd2);
        check("cd_clr_int0", {31'd0, INT0}, 32'd0);

        // One-shot
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'h5);
        check_reg("os_count2", 2'd2, 32'd2);
        tick(); tick();
        check_reg("os_count0", 2'd2, 32'd0);
        check_reg("os_status_pre", 2'd3, 32'd0);
        tick();
        check_reg("os_ctrl", 2'd0, 32'h4);
        check_reg("os_tpend", 2'd3, 32'd1);
        check("os_int0", {31'd0, INT0}, 32'd1);
        tick(); tick();
        check_reg("os_count_hold", 2'd2, 32'd0);
        check("os_int0_hold", {31'd0, INT0}, 32'd1);

        // Clear race: EN written with COUNT == 0 expires on next edge, same as W1C
        bus_write(2'd0, 32'h5);
        bus_write(2'd3, 32'h1);
        check_reg("race_tpend_kept", 2'd3, 32'd1);
        check_reg("race_ctrl", 2'd0, 32'h4);
        bus_write(2'd3, 32'h1);
        check_reg("race_tpend_clr", 2'd3, 32'd0);
        check("race_int0", {31'd0, INT0}, 32'd0);

        // External edge: EPEND 3 cycles after the change, no retrigger on held level
        bus_write(2'd0, 32'h8);
        ext_irq = 1'b1;
        tick(); check_reg("ext_e1", 2'd3, 32'd0);
        tick(); check_reg("ext_e2", 2'd3, 32'd0);
        check("ext_int0_pre", {31'd0, INT0}, 32'd0);
        tick(); check_reg("ext_e3", 2'd3, 32'd2);
        check("ext_int0", {31'd0, INT0}, 32'd1);
        bus_write(2'd3, 32'h2);
        for (int i = 0; i < 6; i++) begin
            check_reg("ext_no_retrig", 2'd3, 32'd0);
            tick();
        end
        check("ext_int0_clr", {31'd0, INT0}, 32'd0);
        ext_irq = 1'b0;

        // LOAD = 0 with auto-reload expires every cycle; LOAD write beats expiry
        bus_write(2'd1, 32'd0);
        bus_write(2'd0, 32'h3);
        tick();
        check_reg("ar0_tpend", 2'd3, 32'd1);
        bus_write(2'd3, 32'h1);
        check_reg("ar0_set_wins", 2'd3, 32'd1);
        check_reg("ar0_count", 2'd2, 32'd0);
        bus_write(2'd1, 32'd7);
        check_reg("ar0_load_wins", 2'd2, 32'd7);
        bus_write(2'd0, 32'h0);
        bus_write(2'd3, 32'h1);

        // Decode: out-of-window write and COUNT write are ignored
        bus.addr  = BASE + 32'd16;
        bus.wdata = 32'hFFFF_FFFF;
        bus.we    = 1'b1;
        #1;
        check("dec_sel", {31'd0, bus.sel}, 32'd0);
        check("dec_rdata", bus.rdata, 32'd0);
        tick();
        bus.we = 1'b0;
        check_reg("dec_ctrl", 2'd0, 32'd0);
        check_reg("dec_load", 2'd1, 32'd7);
        check_reg("dec_status", 2'd3, 32'd0);
        bus_write(2'd2, 32'h55);
        check_reg("dec_count_ro", 2'd2, 32'd6);

        // Asynchronous reset mid-countdown with ext_irq held high
        ext_irq = 1'b1;
        bus_write(2'd1, 32'd100);
        bus_write(2'd0, 32'hF);
        tick(); tick(); tick();
        check_reg("ar_count", 2'd2, 32'd97);
        check("ar_int0_pre", {31'd0, INT0}, 32'd1);
        #4 rst = 1'b1;
        #1;
        check("ar_int0", {31'd0, INT0}, 32'd0);
        check_reg("ar_ctrl", 2'd0, 32'd0);
        check_reg("ar_load", 2'd1, 32'd0);
        check_reg("ar_count0", 2'd2, 32'd0);
        check_reg("ar_status", 2'd3, 32'd0);
        #2 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_reg("ar_no_epend", 2'd3, 32'd0);
        end
        bus_write(2'd0, 32'h8);
        check("ar_int0_post", {31'd0, INT0}, 32'd0);
        ext_irq = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
